// File: rtl/reg_wb_arbiter_pkg.sv
// CpuPkg: shared CPU types for the register-file write-port controller.
//   type_RegAddr : 5-bit architectural register index
//   type_CpuData : 32-bit register value
//   REG_ZERO     : index of x0, which is never written
//   type_WbReq   : one writeback request bus {Rd, Data}
//   type_WbGrant : which writeback source owns the write port this cycle
package CpuPkg;

   typedef logic [4:0]  type_RegAddr;
   typedef logic [31:0] type_CpuData;

   localparam type_RegAddr REG_ZERO = 5'd0;

   typedef struct packed {
      type_RegAddr Rd;
      type_CpuData Data;
   } type_WbReq;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_SRC0 = 2'd1,
      GNT_SRC1 = 2'd2
   } type_WbGrant;

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// reg_scoreboard: busy-bit vector for destinations owned by in-flight
// long-latency ops.
//   clk, rstn        : clock, asynchronous active-low reset (clears all bits)
//   setEn / setIdx   : mark a register busy at the next edge
//   clrEn / clrIdx   : release a register at the next edge (set wins on a tie)
//   rs1/rs2, qIdx    : combinational lookup indices
//   rs1Busy/rs2Busy/qBusy : current busy bits for those indices
module reg_scoreboard
   import CpuPkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        setEn,
   input  type_RegAddr setIdx,
   input  logic        clrEn,
   input  type_RegAddr clrIdx,
   input  type_RegAddr rs1,
   input  type_RegAddr rs2,
   input  type_RegAddr qIdx,
   output logic        rs1Busy,
   output logic        rs2Busy,
   output logic        qBusy
);

   logic [31:0] busy;
   logic [31:0] busyNext;

   always_comb begin
      busyNext = busy;
      if (clrEn) busyNext[clrIdx] = 1'b0;
      // Applied after the clear so a same-cycle set of the same index wins.
      if (setEn) busyNext[setIdx] = 1'b1;
      busyNext[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy <= '0;
      else       busy <= busyNext;
   end

   assign rs1Busy = busy[rs1];
   assign rs2Busy = busy[rs2];
   assign qBusy   = busy[qIdx];

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: single write-port controller for the 32x32 register file.
// Arbitrates between pipeline writeback (src0) and long-latency writeback
// (src1) with a starvation guard, drives a registered write port, and tracks
// busy destinations so decode can stall on RAW/WAW hazards.
//   clk, rstn                     : clock, asynchronous active-low reset
//   issueValid/issueRd/issueReady : long-latency issue; stalls on busy rd
//   rs1/rs2 -> rs1Busy/rs2Busy    : decode source hazard lookup
//   wb0Valid/wb0Rd/wb0Data/wb0Ready : pipeline writeback handshake
//   wb1Valid/wb1Rd/wb1Data/wb1Ready : long-latency writeback handshake
//   rfWe/rfRd/rfData              : register file write port (1-cycle latency)
module reg_wb_arbiter
   import CpuPkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        issueValid,
   input  type_RegAddr issueRd,
   output logic        issueReady,
   input  type_RegAddr rs1,
   input  type_RegAddr rs2,
   output logic        rs1Busy,
   output logic        rs2Busy,
   input  logic        wb0Valid,
   input  type_RegAddr wb0Rd,
   input  type_CpuData wb0Data,
   output logic        wb0Ready,
   input  logic        wb1Valid,
   input  type_RegAddr wb1Rd,
   input  type_CpuData wb1Data,
   output logic        wb1Ready,
   output logic        rfWe,
   output type_RegAddr rfRd,
   output type_CpuData rfData
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   type_WbReq   req0;
   type_WbReq   req1;
   type_WbReq   winReq;
   type_WbGrant grant;
   logic [3:0]  starveCnt;
   logic [3:0]  starveNext;
   logic        issueBusy;
   logic        issueSet;

   assign req0 = '{Rd: wb0Rd, Data: wb0Data};
   assign req1 = '{Rd: wb1Rd, Data: wb1Data};

   always_comb begin
      grant  = GNT_NONE;
      winReq = req0;
      if (wb1Valid && (!wb0Valid || starveCnt == LIMIT)) begin
         grant  = GNT_SRC1;
         winReq = req1;
      end else if (wb0Valid) begin
         grant = GNT_SRC0;
      end
   end

   assign wb0Ready = (grant == GNT_SRC0);
   assign wb1Ready = (grant == GNT_SRC1);

   // Counts only cycles where src1 waits behind src0; any src1 grant or
   // src1 going idle restarts the window.
   always_comb begin
      starveNext = starveCnt;
      if (!wb1Valid || grant == GNT_SRC1)
         starveNext = '0;
      else if (grant == GNT_SRC0 && starveCnt != LIMIT)
         starveNext = starveCnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) starveCnt <= '0;
      else       starveCnt <= starveNext;
   end

   // Write register: rd/data follow every grant (x0 included), the enable
   // only for non-zero destinations; idle cycles hold rd/data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rfWe   <= 1'b0;
         rfRd   <= REG_ZERO;
         rfData <= '0;
      end else begin
         rfWe <= 1'b0;
         if (grant != GNT_NONE) begin
            rfWe   <= (winReq.Rd != REG_ZERO);
            rfRd   <= winReq.Rd;
            rfData <= winReq.Data;
         end
      end
   end

   assign issueReady = (issueRd == REG_ZERO) || !issueBusy;
   assign issueSet   = issueValid && issueReady && (issueRd != REG_ZERO);

   reg_scoreboard u_scoreboard (
      .clk     (clk),
      .rstn    (rstn),
      .setEn   (issueSet),
      .setIdx  (issueRd),
      .clrEn   (wb1Ready),
      .clrIdx  (wb1Rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .qIdx    (issueRd),
      .rs1Busy (rs1Busy),
      .rs2Busy (rs2Busy),
      .qBusy   (issueBusy)
   );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: expected write-port results are
// queued when a request is driven and compared one cycle later.
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issueValid;
   logic [4:0]  issueRd;
   logic        issueReady;
   logic [4:0]  rs1, rs2;
   logic        rs1Busy, rs2Busy;
   logic        wb0Valid, wb1Valid;
   logic [4:0]  wb0Rd, wb1Rd;
   logic [31:0] wb0Data, wb1Data;
   logic        wb0Ready, wb1Ready;
   logic        rfWe;
   logic [4:0]  rfRd;
   logic [31:0] rfData;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rstn(rstn),
      .issueValid(issueValid), .issueRd(issueRd), .issueReady(issueReady),
      .rs1(rs1), .rs2(rs2), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
      .wb0Valid(wb0Valid), .wb0Rd(wb0Rd), .wb0Data(wb0Data), .wb0Ready(wb0Ready),
      .wb1Valid(wb1Valid), .wb1Rd(wb1Rd), .wb1Data(wb1Data), .wb1Ready(wb1Ready),
      .rfWe(rfWe), .rfRd(rfRd), .rfData(rfData)
   );

   // Queue the write-port result expected after the next edge for the given grant.
   task automatic push_exp(input logic g0, input logic g1);
      exp_t x;
      if (g1) begin
         hold_rd = wb1Rd; hold_data = wb1Data;
         x = '{we: (wb1Rd != 5'd0), rd: wb1Rd, data: wb1Data};
      end else if (g0) begin
         hold_rd = wb0Rd; hold_data = wb0Data;
         x = '{we: (wb0Rd != 5'd0), rd: wb0Rd, data: wb0Data};
      end else begin
         x = '{we: 1'b0, rd: hold_rd, data: hold_data};
      end
      q.push_back(x);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      issueValid = 0; issueRd = 0; rs1 = 0; rs2 = 0;
      wb0Valid = 0; wb0Rd = 0; wb0Data = 0;
      wb1Valid = 0; wb1Rd = 0; wb1Data = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 0; hold_rd = 0; hold_data = 0;
      #12;
      checks++;
      if ({rfWe, rfRd, rfData, rs1Busy, wb0Ready, wb1Ready, issueReady} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got we=%b rd=%0d data=%h rs1Busy=%b r0=%b r1=%b iR=%b, need 0 0 0 0 0 0 1",
                  rfWe, rfRd, rfData, rs1Busy, wb0Ready, wb1Ready, issueReady);
      end
      @(negedge clk); rstn = 1;
   endtask

   task automatic test_wb0();
      @(negedge clk);
      wb0Valid = 1; wb0Rd = 5; wb0Data = 32'h1234; #1;
      checks++;
      if ({wb0Ready, wb1Ready} !== 2'b10) begin
         errors++; $display("FAIL wb0_grant: got r0=%b r1=%b, need 1 0", wb0Ready, wb1Ready);
      end
      push_exp(1, 0); step(); wb0Valid = 0;
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData} !== e) begin
         errors++; $display("FAIL wb0_write: got %b/%0d/%h, need %b/%0d/%h", rfWe, rfRd, rfData, e.we, e.rd, e.data);
      end
      @(negedge clk); #1; push_exp(0, 0); step();
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData} !== e) begin
         errors++; $display("FAIL idle_hold: got %b/%0d/%h, need %b/%0d/%h", rfWe, rfRd, rfData, e.we, e.rd, e.data);
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      issueValid = 1; issueRd = 7; #1;
      checks++;
      if (issueReady !== 1'b1) begin errors++; $display("FAIL issue_ready_free: got %b need 1", issueReady); end
      step(); issueValid = 0;
      @(negedge clk); rs1 = 7; rs2 = 8; #1;
      checks++;
      if ({rs1Busy, rs2Busy, issueReady} !== 3'b100) begin
         errors++; $display("FAIL busy_after_issue: got rs1B=%b rs2B=%b iR=%b, need 1 0 0", rs1Busy, rs2Busy, issueReady);
      end
      wb1Valid = 1; wb1Rd = 7; wb1Data = 32'hBEEF; #1;
      checks++;
      if ({wb0Ready, wb1Ready} !== 2'b01) begin
         errors++; $display("FAIL wb1_grant: got r0=%b r1=%b, need 0 1", wb0Ready, wb1Ready);
      end
      push_exp(0, 1); step(); wb1Valid = 0;
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData, rs1Busy} !== {e, 1'b0}) begin
         errors++; $display("FAIL wb1_write_clear: got %b/%0d/%h rs1B=%b, need %b/%0d/%h rs1B=0",
                            rfWe, rfRd, rfData, rs1Busy, e.we, e.rd, e.data);
      end
      // WAW: src0 write to a busy rd is performed and busy stays set.
      @(negedge clk); issueValid = 1; issueRd = 10; step(); issueValid = 0;
      @(negedge clk); rs1 = 10; wb0Valid = 1; wb0Rd = 10; wb0Data = 32'hCAFE0010; #1;
      push_exp(1, 0); step(); wb0Valid = 0;
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData, rs1Busy} !== {e, 1'b1}) begin
         errors++; $display("FAIL waw_src0: got %b/%0d/%h rs1B=%b, need %b/%0d/%h rs1B=1",
                            rfWe, rfRd, rfData, rs1Busy, e.we, e.rd, e.data);
      end
   endtask

   task automatic test_starvation();
      @(negedge clk);
      wb0Valid = 1; wb0Rd = 1; wb1Valid = 1; wb1Rd = 2; wb1Data = 32'hB0B0_0002;
      for (int i = 0; i < 10; i++) begin
         logic g1;
         wb0Data = 32'hA000_0000 + i; #1;
         g1 = (i % 5 == 4);
         checks++;
         if ({wb0Ready, wb1Ready} !== {~g1, g1}) begin
            errors++; $display("FAIL starve_grant[%0d]: got r0=%b r1=%b, need %b %b", i, wb0Ready, wb1Ready, ~g1, g1);
         end
         push_exp(~g1, g1); step();
         e = q.pop_front(); checks++;
         if ({rfWe, rfRd, rfData} !== e) begin
            errors++; $display("FAIL starve_write[%0d]: got %b/%0d/%h, need %b/%0d/%h", i, rfWe, rfRd, rfData, e.we, e.rd, e.data);
         end
         @(negedge clk);
      end
      wb0Valid = 0; wb1Valid = 0;
   endtask

   task automatic test_x0();
      @(negedge clk);
      wb0Valid = 1; wb0Rd = 0; wb0Data = 32'hFFFF; issueValid = 1; issueRd = 0; rs1 = 0; #1;
      checks++;
      if ({wb0Ready, issueReady} !== 2'b11) begin
         errors++; $display("FAIL x0_ready: got r0=%b iR=%b, need 1 1", wb0Ready, issueReady);
      end
      push_exp(1, 0); step(); wb0Valid = 0; issueValid = 0;
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData, rs1Busy, issueReady} !== {e, 1'b0, 1'b1}) begin
         errors++; $display("FAIL x0_write: got %b/%0d/%h rs1B=%b iR=%b, need %b/%0d/%h 0 1",
                            rfWe, rfRd, rfData, rs1Busy, issueReady, e.we, e.rd, e.data);
      end
   endtask

   task automatic test_conflict();
      @(negedge clk);
      wb1Valid = 1; wb1Rd = 9; wb1Data = 32'h9; issueValid = 1; issueRd = 9; rs1 = 9; #1;
      checks++;
      if ({wb1Ready, issueReady} !== 2'b11) begin
         errors++; $display("FAIL conflict_ready: got r1=%b iR=%b, need 1 1", wb1Ready, issueReady);
      end
      push_exp(0, 1); step(); wb1Valid = 0; issueValid = 0;
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData, rs1Busy} !== {e, 1'b1}) begin
         errors++; $display("FAIL conflict_set_wins: got %b/%0d/%h rs1B=%b, need %b/%0d/%h 1",
                            rfWe, rfRd, rfData, rs1Busy, e.we, e.rd, e.data);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      issueValid = 1; issueRd = 3; step(); issueValid = 0;
      @(negedge clk);
      rs2 = 3; wb0Valid = 1; wb0Rd = 4; wb0Data = 32'h44; wb1Valid = 1; wb1Rd = 6; wb1Data = 32'h66;
      push_exp(1, 0); step();
      e = q.pop_front(); checks++;
      if ({rfWe, rfRd, rfData, rs2Busy} !== {e, 1'b1}) begin
         errors++; $display("FAIL pre_reset: got %b/%0d/%h rs2B=%b, need %b/%0d/%h 1",
                            rfWe, rfRd, rfData, rs2Busy, e.we, e.rd, e.data);
      end
      #2; rstn = 0; #1;
      checks++;
      if ({rfWe, rfRd, rfData, rs2Busy} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
         errors++; $display("FAIL mid_reset: got %b/%0d/%h rs2B=%b, need 0/0/0 0", rfWe, rfRd, rfData, rs2Busy);
      end
      hold_rd = 0; hold_data = 0;
      @(negedge clk); rstn = 1;
      for (int i = 0; i < 5; i++) begin
         logic g1;
         #1; g1 = (i == 4);
         checks++;
         if ({wb0Ready, wb1Ready} !== {~g1, g1}) begin
            errors++; $display("FAIL post_reset_grant[%0d]: got r0=%b r1=%b, need %b %b", i, wb0Ready, wb1Ready, ~g1, g1);
         end
         push_exp(~g1, g1); step();
         e = q.pop_front(); checks++;
         if ({rfWe, rfRd, rfData} !== e) begin
            errors++; $display("FAIL post_reset_write[%0d]: got %b/%0d/%h, need %b/%0d/%h", i, rfWe, rfRd, rfData, e.we, e.rd, e.data);
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_wb0();
      test_scoreboard();
      test_starvation();
      test_x0();
      test_conflict();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
